// File: rtl/player_link_tx.sv
// Serial uplink of the local player's state to the remote board.
// One 19-bit frame (start, 16 payload LSB first, even parity, stop) per frame tick.
module player_link_tx #(
    parameter int CLKS_PER_BIT = 65
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_tick,
    input  logic        m_left,
    input  logic        m_right,
    input  logic [1:0]  button_pressed,
    input  logic [11:0] xpos_player,
    output logic        gpio_left,
    output logic        gpio_right,
    output logic        gpio_tx,
    output logic        busy,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [11:0] LAST = 12'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        over_q, over_d;
    logic        vt_q, arm_q;
    logic        left_q, right_q;
    logic        tick_edge, bit_done, ld;
    logic [15:0] payload;

    always_comb begin
        payload   = {m_left, m_right, button_pressed, xpos_player};
        tick_edge = v_tick & ~vt_q & arm_q;
        bit_done  = (cnt_q == LAST);
        state_d   = state_q;
        cnt_d     = 12'd0;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        over_d    = over_q;
        ld        = 1'b0;
        tx_d      = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    state_d = START;
                    ld      = 1'b1;
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == 4'd15) begin
                        state_d = PARITY;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        shift_d = {1'b0, shift_q[15:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    if (pend_v_q || tick_edge) begin
                        state_d = START;
                        ld      = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !bit_done) cnt_d = cnt_q + 12'd1;

        // A snapshot taken the cycle a frame is loaded never counts as an overrun
        if (ld) begin
            shift_d  = pend_v_q ? pend_q : payload;
            par_d    = ^shift_d;
            idx_d    = 4'd0;
            pend_v_d = pend_v_q & tick_edge;
            if (tick_edge) pend_d = payload;
        end else if (tick_edge) begin
            pend_d   = payload;
            pend_v_d = 1'b1;
            over_d   = over_q | pend_v_q;
        end

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 12'd0;
            idx_q    <= 4'd0;
            shift_q  <= 16'd0;
            pend_q   <= 16'd0;
            pend_v_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            over_q   <= 1'b0;
            vt_q     <= 1'b0;
            arm_q    <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            over_q   <= over_d;
            vt_q     <= v_tick;
            // A tick held high through reset must fall once before it can fire
            arm_q    <= arm_q | ~v_tick;
            left_q   <= m_left;
            right_q  <= m_right;
        end
    end

    assign gpio_tx    = tx_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = over_q;
    assign gpio_left  = left_q;
    assign gpio_right = right_q;
endmodule
